// File: rtl/hist_pkg.sv
// Shared types and constants for the histogram read-modify-write controller.
package hist_pkg;

    localparam int HIST_ADDR_W = 10;
    localparam int HIST_DATA_W = 32;

    // Wide enough for any supported counter width; sliced down to DATA_W at use.
    localparam logic [63:0] HIST_CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        UPD_RD,
        UPD_WR,
        CLR,
        HRD_RD,
        HRD_DATA
    } hist_state_t;

    typedef struct packed {
        logic [HIST_ADDR_W-1:0]   address;
        logic                     clken;
        logic                     chipselect;
        logic                     write;
        logic [HIST_DATA_W-1:0]   writedata;
        logic [HIST_DATA_W/8-1:0] byteenable;
    } hist_s1_t;

endpackage

// File: rtl/hist_rmw_ctrl_if.sv
// Avalon-MM s1 port of the histogram SRAM; the controller is the master side.
interface hist_rmw_ctrl_if import hist_pkg::*; #(
    parameter int ADDR_W = HIST_ADDR_W,
    parameter int DATA_W = HIST_DATA_W
);

    logic [ADDR_W-1:0]   address;
    logic                clken;
    logic                chipselect;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, clken, chipselect, write, writedata, byteenable,
        input  readdata
    );

    modport slave (
        input  address, clken, chipselect, write, writedata, byteenable,
        output readdata
    );

endinterface

// File: rtl/onehot_decode.sv
// Converts a one-hot bin vector to its binary index; an all-zero input gives 0.
module onehot_decode #(
    parameter int NUM_BINS = 3,
    parameter int OUT_W    = 10
) (
    input  logic [NUM_BINS-1:0] onehot,
    output logic [OUT_W-1:0]    index
);

    // OR of the indices of set bits; only meaningful when exactly one bit is set.
    always_comb begin
        index = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (onehot[i]) begin
                index = index | OUT_W'(i);
            end
        end
    end

endmodule

// File: rtl/hist_rmw_ctrl.sv
// Histogram SRAM sequencer: saturating bin increments, full-table clear and host
// readout, all arbitrated onto one Avalon s1 port with read latency 1.
module hist_rmw_ctrl import hist_pkg::*; #(
    parameter int NUM_BINS = 3,
    parameter int ADDR_W   = HIST_ADDR_W,
    parameter int DATA_W   = HIST_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hit_valid,
    input  logic [NUM_BINS-1:0] hit_onehot,
    output logic                hit_ready,
    output logic                hit_err,
    input  logic                clr_start,
    output logic                clr_busy,
    output logic                clr_done,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_bin,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    hist_rmw_ctrl_if.master     mem
);

    localparam logic [DATA_W-1:0] CNT_MAX  = HIST_CNT_MAX[DATA_W-1:0];
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);

    hist_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic              hit_err_q, hit_err_d;
    logic              clr_pend_q, clr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_bin_q, rd_bin_d;
    logic              clr_busy_q, clr_busy_d;
    logic              clr_done_q, clr_done_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              clken_q;

    logic [ADDR_W-1:0] hit_addr;
    logic              hit_ok;
    logic              hit_accept;
    logic [DATA_W-1:0] cnt_inc;

    onehot_decode #(
        .NUM_BINS (NUM_BINS),
        .OUT_W    (ADDR_W)
    ) u_decode (
        .onehot (hit_onehot),
        .index  (hit_addr)
    );

    assign hit_ok     = ($countones(hit_onehot) == 1);
    assign hit_ready  = !rst && (state_q == IDLE) && !clr_pend_q && !rd_pend_q;
    assign hit_accept = hit_valid && hit_ready;

    // The read word only arrives in UPD_WR, so the increment is formed from it directly.
    assign cnt_inc = (mem.readdata == CNT_MAX) ? CNT_MAX : mem.readdata + DATA_W'(1);

    assign mem.address    = addr_q;
    assign mem.clken      = clken_q;
    assign mem.chipselect = cs_q;
    assign mem.write      = wr_q;
    assign mem.writedata  = (state_q == UPD_WR) ? cnt_inc : '0;
    assign mem.byteenable = '1;

    assign hit_err  = hit_err_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            hit_err_q  <= 1'b0;
            clr_pend_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_bin_q   <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            clken_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            hit_err_q  <= hit_err_d;
            clr_pend_q <= clr_pend_d;
            rd_pend_q  <= rd_pend_d;
            rd_bin_q   <= rd_bin_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            clken_q    <= 1'b1;
        end
    end

    // Requests latch in every state; IDLE grants clear, then host read, then hits.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cs_d       = 1'b0;
        wr_d       = 1'b0;
        hit_err_d  = 1'b0;
        clr_done_d = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        clr_pend_d = clr_pend_q | clr_start;
        rd_pend_d  = rd_pend_q | rd_req;
        rd_bin_d   = (rd_req && !rd_pend_q) ? rd_bin : rd_bin_q;

        case (state_q)
            IDLE: begin
                if (clr_pend_q) begin
                    state_d    = CLR;
                    addr_d     = '0;
                    cs_d       = 1'b1;
                    wr_d       = 1'b1;
                    clr_pend_d = clr_start;
                end else if (rd_pend_q) begin
                    state_d   = HRD_RD;
                    addr_d    = rd_bin_q;
                    cs_d      = 1'b1;
                    rd_pend_d = rd_req;
                    rd_bin_d  = rd_req ? rd_bin : rd_bin_q;
                end else if (hit_accept) begin
                    if (hit_ok) begin
                        state_d = UPD_RD;
                        addr_d  = hit_addr;
                        cs_d    = 1'b1;
                    end else begin
                        hit_err_d = 1'b1;
                    end
                end
            end
            UPD_RD: begin
                state_d = UPD_WR;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
            end
            UPD_WR: begin
                state_d = IDLE;
            end
            CLR: begin
                if (addr_q == LAST_BIN) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    cs_d   = 1'b1;
                    wr_d   = 1'b1;
                end
            end
            HRD_RD: begin
                state_d = HRD_DATA;
            end
            HRD_DATA: begin
                state_d    = IDLE;
                rd_data_d  = mem.readdata;
                rd_valid_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        clr_busy_d = clr_pend_d | (state_d == CLR) | clr_done_d;
    end

endmodule

// File: tb/tb_hist_rmw_ctrl.sv
// Directed bench for hist_rmw_ctrl with a latency-1 SRAM model on the s1 port.
module tb_hist_rmw_ctrl;

    logic        clk;
    logic        rst;
    logic        hit_valid;
    logic [2:0]  hit_onehot;
    logic        hit_ready;
    logic        hit_err;
    logic        clr_start;
    logic        clr_busy;
    logic        clr_done;
    logic        rd_req;
    logic [9:0]  rd_bin;
    logic        rd_valid;
    logic [31:0] rd_data;

    logic        pre_en;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] ram [0:1023];

    int vec_count;
    int miss_count;

    typedef struct packed {
        logic [2:0]  onehot;
        logic        err;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } hit_vec_t;

    hit_vec_t vecs [8];

    hist_rmw_ctrl_if #(.ADDR_W(10), .DATA_W(32)) mem_if ();

    hist_rmw_ctrl #(
        .NUM_BINS (3),
        .ADDR_W   (10),
        .DATA_W   (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hit_valid  (hit_valid),
        .hit_onehot (hit_onehot),
        .hit_ready  (hit_ready),
        .hit_err    (hit_err),
        .clr_start  (clr_start),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .rd_req     (rd_req),
        .rd_bin     (rd_bin),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .mem        (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: write or latency-1 read when enabled; bench preload port wins.
    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_if.clken && mem_if.chipselect) begin
            if (mem_if.write) begin
                ram[mem_if.address] <= mem_if.writedata;
            end else begin
                mem_if.readdata <= ram[mem_if.address];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Starts and ends at the falling edge of an IDLE cycle.
    task automatic applyStimulus(input string name, input hit_vec_t v);
        checkOutput({name, ".ready"}, hit_ready, 1);
        hit_valid  = 1'b1;
        hit_onehot = v.onehot;
        @(negedge clk);
        hit_valid  = 1'b0;
        hit_onehot = 3'b000;
        if (v.err) begin
            checkOutput({name, ".err"}, hit_err, 1);
            checkOutput({name, ".cs_err"}, mem_if.chipselect, 0);
        end else begin
            checkOutput({name, ".err0"}, hit_err, 0);
            checkOutput({name, ".rd_cs"}, {mem_if.chipselect, mem_if.write}, 2'b10);
            checkOutput({name, ".rd_addr"}, mem_if.address, v.addr);
            checkOutput({name, ".rd_ready"}, hit_ready, 0);
            @(negedge clk);
            checkOutput({name, ".wr_cs"}, {mem_if.chipselect, mem_if.write}, 2'b11);
            checkOutput({name, ".wr_addr"}, mem_if.address, v.addr);
            checkOutput({name, ".wr_data"}, mem_if.writedata, v.wdata);
            checkOutput({name, ".wr_ready"}, hit_ready, 0);
            @(negedge clk);
            checkOutput({name, ".idle_cs"}, mem_if.chipselect, 0);
        end
    endtask

    task automatic doClear();
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        checkOutput("clr.busy_pend", clr_busy, 1);
        checkOutput("clr.ready_pend", hit_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("clr.cs%0d", k), {mem_if.chipselect, mem_if.write}, 2'b11);
            checkOutput($sformatf("clr.addr%0d", k), mem_if.address, k);
            checkOutput($sformatf("clr.data%0d", k), mem_if.writedata, 0);
        end
        @(negedge clk);
        checkOutput("clr.done", clr_done, 1);
        checkOutput("clr.busy_done", clr_busy, 1);
        checkOutput("clr.cs_done", mem_if.chipselect, 0);
        @(negedge clk);
        checkOutput("clr.done_end", clr_done, 0);
        checkOutput("clr.busy_end", clr_busy, 0);
    endtask

    task automatic doRead(input logic [9:0] bin, input logic [31:0] exp);
        rd_req = 1'b1;
        rd_bin = bin;
        @(negedge clk);
        rd_req = 1'b0;
        checkOutput("rd.grant_cs", mem_if.chipselect, 0);
        @(negedge clk);
        checkOutput("rd.cs", {mem_if.chipselect, mem_if.write}, 2'b10);
        checkOutput("rd.addr", mem_if.address, bin);
        @(negedge clk);
        checkOutput("rd.valid_early", rd_valid, 0);
        @(negedge clk);
        checkOutput("rd.valid", rd_valid, 1);
        checkOutput($sformatf("rd.data_bin%0d", bin), rd_data, exp);
        @(negedge clk);
        checkOutput("rd.valid_end", rd_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_count  = 0;
        miss_count = 0;
        rst        = 1'b1;
        hit_valid  = 1'b0;
        hit_onehot = 3'b000;
        clr_start  = 1'b0;
        rd_req     = 1'b0;
        rd_bin     = '0;
        pre_en     = 1'b0;
        pre_addr   = '0;
        pre_data   = '0;

        vecs[0] = '{3'b001, 1'b0, 10'd0, 32'd1};
        vecs[1] = '{3'b100, 1'b0, 10'd2, 32'd1};
        vecs[2] = '{3'b100, 1'b0, 10'd2, 32'd2};
        vecs[3] = '{3'b000, 1'b1, 10'd0, 32'd0};
        vecs[4] = '{3'b011, 1'b1, 10'd0, 32'd0};
        vecs[5] = '{3'b010, 1'b0, 10'd1, 32'd1};
        vecs[6] = '{3'b100, 1'b0, 10'd2, 32'd3};
        vecs[7] = '{3'b001, 1'b0, 10'd0, 32'd2};

        repeat (2) @(negedge clk);
        checkOutput("rst.ready", hit_ready, 0);
        checkOutput("rst.clken", mem_if.clken, 0);
        checkOutput("rst.cs_wr", {mem_if.chipselect, mem_if.write}, 2'b00);
        checkOutput("rst.busy", clr_busy, 0);
        checkOutput("rst.rd_valid", rd_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post.clken", mem_if.clken, 1);
        checkOutput("post.ready", hit_ready, 1);
        checkOutput("post.byteenable", mem_if.byteenable, 4'hF);

        doClear();
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end
        doRead(10'd0, 32'd2);
        doRead(10'd1, 32'd1);
        doRead(10'd2, 32'd3);

        // Saturation: bin 1 preloaded one below the maximum.
        pre_en   = 1'b1;
        pre_addr = 10'd1;
        pre_data = 32'hFFFF_FFFE;
        @(negedge clk);
        pre_en = 1'b0;
        applyStimulus("sat0", '{3'b010, 1'b0, 10'd1, 32'hFFFF_FFFF});
        applyStimulus("sat1", '{3'b010, 1'b0, 10'd1, 32'hFFFF_FFFF});
        doRead(10'd1, 32'hFFFF_FFFF);

        // Clear and read requested while a hit is in UPD_RD.
        hit_valid  = 1'b1;
        hit_onehot = 3'b010;
        @(negedge clk);
        hit_valid  = 1'b0;
        hit_onehot = 3'b000;
        checkOutput("cor.rd_cs", {mem_if.chipselect, mem_if.write}, 2'b10);
        clr_start = 1'b1;
        rd_req    = 1'b1;
        rd_bin    = 10'd1;
        @(negedge clk);
        clr_start = 1'b0;
        rd_req    = 1'b0;
        checkOutput("cor.wr_cs", {mem_if.chipselect, mem_if.write}, 2'b11);
        checkOutput("cor.wr_addr", mem_if.address, 1);
        checkOutput("cor.wr_data", mem_if.writedata, 32'hFFFF_FFFF);
        checkOutput("cor.busy", clr_busy, 1);
        @(negedge clk);
        checkOutput("cor.gap_cs", mem_if.chipselect, 0);
        checkOutput("cor.gap_ready", hit_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("cor.clr_cs%0d", k), {mem_if.chipselect, mem_if.write}, 2'b11);
            checkOutput($sformatf("cor.clr_addr%0d", k), mem_if.address, k);
        end
        @(negedge clk);
        checkOutput("cor.done", clr_done, 1);
        @(negedge clk);
        checkOutput("cor.hrd_cs", {mem_if.chipselect, mem_if.write}, 2'b10);
        checkOutput("cor.hrd_addr", mem_if.address, 1);
        checkOutput("cor.busy_end", clr_busy, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("cor.rd_valid", rd_valid, 1);
        checkOutput("cor.rd_data", rd_data, 0);
        @(negedge clk);

        // Five hits on bin 2 after the clear, then host readout.
        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("b2hit%0d", i), '{3'b100, 1'b0, 10'd2, 32'(i + 1)});
        end
        doRead(10'd2, 32'd5);

        // Reset while the clear sweep is writing address 1.
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstclr.addr1", mem_if.address, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstclr.cs_wr", {mem_if.chipselect, mem_if.write}, 2'b00);
        checkOutput("rstclr.addr", mem_if.address, 0);
        checkOutput("rstclr.wdata", mem_if.writedata, 0);
        checkOutput("rstclr.clken", mem_if.clken, 0);
        checkOutput("rstclr.flags", {clr_busy, clr_done, rd_valid, hit_err, hit_ready}, 5'b00000);
        checkOutput("rstclr.rd_data", rd_data, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstclr.clken_up", mem_if.clken, 1);
        checkOutput("rstclr.ready_up", hit_ready, 1);
        doRead(10'd2, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
